// File: rtl/flash_sched.sv
// flash_sched: grants one of two requesters the flasher, drives the flick
// line through start and an optional single kickback, guards each run with a
// watchdog and counts completed runs.
module flash_sched #(
  parameter logic [7:0] TMO   = 8'd200,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       req_kick,
  input  logic [2:0]       fl_state,
  input  logic             err_clr,
  output logic [1:0]       gnt,
  output logic             flick,
  output logic             busy,
  output logic [1:0]       done,
  output logic             err,
  output logic [CNT_W-1:0] run_cnt
);

  typedef enum logic [1:0] {IDLE, START, RUN, CMPL} state_t;

  localparam logic [2:0] FL_INIT    = 3'b000;
  localparam logic [2:0] FL_ST_0_15 = 3'b001;
  localparam logic [2:0] FL_ST_15_5 = 3'b010;
  // Last watchdog value before expiry: TMO cycles spent in START/RUN.
  localparam logic [7:0] WD_LAST    = TMO - 8'd1;

  state_t           state, state_next;
  logic [1:0]       gnt_next, done_next;
  logic             owner, owner_next;
  logic             last, last_next;        // requester granted most recently
  logic             kick_pend, kick_next;
  logic             seen_55, seen_next;     // flasher has visited ST_15_5 this run
  logic [7:0]       wd, wd_next;
  logic             err_next;
  logic [CNT_W-1:0] cnt_next;
  logic             win;

  // Round-robin winner: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
  end

  // Next-state and registered-output logic for the run sequence and watchdog.
  always_comb begin
    state_next = state;
    gnt_next   = 2'b00;
    done_next  = 2'b00;
    owner_next = owner;
    last_next  = last;
    kick_next  = kick_pend;
    seen_next  = seen_55;
    wd_next    = wd;
    err_next   = err & ~err_clr;
    cnt_next   = run_cnt;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_next   = win ? 2'b10 : 2'b01;
          owner_next = win;
          last_next  = win;
          kick_next  = req_kick[win];
          seen_next  = 1'b0;
          wd_next    = 8'd0;
          state_next = START;
        end
      end
      START, RUN: begin
        if (wd == WD_LAST) begin
          // Watchdog expiry overrides any flasher progress this cycle.
          err_next   = 1'b1;
          kick_next  = 1'b0;
          wd_next    = 8'd0;
          state_next = IDLE;
        end else begin
          wd_next = wd + 8'd1;
          if (state == START) begin
            if (fl_state == FL_ST_0_15) state_next = RUN;
          end else begin
            if (fl_state == FL_ST_15_5) seen_next = 1'b1;
            if (fl_state == FL_ST_0_15 && seen_55) kick_next = 1'b0;
            if (fl_state == FL_INIT) begin
              state_next = CMPL;
              done_next  = owner ? 2'b10 : 2'b01;
              if (run_cnt != '1) cnt_next = run_cnt + CNT_W'(1);
            end
          end
        end
      end
      CMPL: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 2'b00;
      done      <= 2'b00;
      owner     <= 1'b0;
      last      <= 1'b1;
      kick_pend <= 1'b0;
      seen_55   <= 1'b0;
      wd        <= 8'd0;
      err       <= 1'b0;
      run_cnt   <= '0;
    end else begin
      state     <= state_next;
      gnt       <= gnt_next;
      done      <= done_next;
      owner     <= owner_next;
      last      <= last_next;
      kick_pend <= kick_next;
      seen_55   <= seen_next;
      wd        <= wd_next;
      err       <= err_next;
      run_cnt   <= cnt_next;
    end
  end

  // Flick drives the flasher in START and during the pending kickback window only.
  always_comb begin
    flick = (state == START) ||
            (state == RUN && kick_pend && fl_state == FL_ST_15_5);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_flash_sched.sv
// Directed testbench for flash_sched with a hand-stepped flasher.
module tb_flash_sched;
  localparam logic [7:0] TMO   = 8'd20;
  localparam int         CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req;
  logic [1:0]       req_kick;
  logic [2:0]       fl_state;
  logic             err_clr;
  logic [1:0]       gnt;
  logic             flick;
  logic             busy;
  logic [1:0]       done;
  logic             err;
  logic [CNT_W-1:0] run_cnt;

  int checks = 0;
  int errors = 0;

  flash_sched #(.TMO(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_kick(req_kick),
    .fl_state(fl_state), .err_clr(err_clr), .gnt(gnt), .flick(flick),
    .busy(busy), .done(done), .err(err), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"}, {6'd0, gnt}, 8'd0);
    chk({tag, "_done"}, {6'd0, done}, 8'd0);
    chk({tag, "_flick"}, {7'd0, flick}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_err"}, {7'd0, err}, 8'd0);
    chk({tag, "_cnt"}, {5'd0, run_cnt}, 8'd0);
  endtask

  // One complete run from IDLE with the flasher stepping 001,010,001,010,001,000.
  task automatic do_run(input logic [1:0] exp_gnt, input logic exp_kick,
                        input logic [CNT_W-1:0] exp_cnt);
    tick();
    chk("run_gnt", {6'd0, gnt}, {6'd0, exp_gnt});
    chk("run_start_flick", {7'd0, flick}, 8'd1);
    fl_state = 3'b001;
    tick();
    chk("run_gnt_pulse", {6'd0, gnt}, 8'd0);
    chk("run_flick_001", {7'd0, flick}, 8'd0);
    fl_state = 3'b010;
    #1;
    chk("run_kick_flick", {7'd0, flick}, {7'd0, exp_kick});
    tick();
    fl_state = 3'b001;
    tick();
    fl_state = 3'b010;
    #1;
    chk("run_second_kick", {7'd0, flick}, 8'd0);
    tick();
    fl_state = 3'b001;
    tick();
    fl_state = 3'b000;
    tick();
    chk("run_done", {6'd0, done}, {6'd0, exp_gnt});
    chk("run_cnt", {5'd0, run_cnt}, {5'd0, exp_cnt});
    chk("run_cmpl_flick", {7'd0, flick}, 8'd0);
    tick();
    chk("run_done_pulse", {6'd0, done}, 8'd0);
    chk("run_idle_busy", {7'd0, busy}, 8'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req = 2'b00; req_kick = 2'b00; fl_state = 3'b000; err_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_zero("reset");
    tick();
    chk("reset_hold_gnt", {6'd0, gnt}, 8'd0);
    rst_n = 1'b1;

    // Single requester 0, no kickback.
    req = 2'b01;
    do_run(2'b01, 1'b0, 3'd1);
    req = 2'b00;
    chk("single_err", {7'd0, err}, 8'd0);

    // Watchdog: flasher stuck in ST_0_15.
    req = 2'b01;
    tick();
    chk("wd_gnt", {6'd0, gnt}, 8'd1);
    req = 2'b00;
    fl_state = 3'b001;
    for (int i = 0; i < int'(TMO) - 1; i++) tick();
    chk("wd_busy_before", {7'd0, busy}, 8'd1);
    chk("wd_err_before", {7'd0, err}, 8'd0);
    tick();
    chk("wd_busy_after", {7'd0, busy}, 8'd0);
    chk("wd_err_after", {7'd0, err}, 8'd1);
    chk("wd_no_done", {6'd0, done}, 8'd0);
    chk("wd_cnt_kept", {5'd0, run_cnt}, 8'd1);
    fl_state = 3'b000;
    tick();
    chk("wd_err_sticky", {7'd0, err}, 8'd1);

    // Second timeout with err_clr held high: the new timeout wins.
    err_clr = 1'b1;
    req = 2'b01;
    tick();
    chk("wd2_clr", {7'd0, err}, 8'd0);
    req = 2'b00;
    fl_state = 3'b001;
    for (int i = 0; i < int'(TMO); i++) tick();
    chk("wd2_set_wins", {7'd0, err}, 8'd1);
    err_clr = 1'b0;
    fl_state = 3'b000;
    tick();
    err_clr = 1'b1;
    tick();
    chk("wd_err_clr", {7'd0, err}, 8'd0);
    err_clr = 1'b0;

    // Reset in RUN with a pending kickback.
    req = 2'b01; req_kick = 2'b01;
    tick();
    req = 2'b00;
    fl_state = 3'b001;
    tick();
    fl_state = 3'b010;
    #1;
    chk("midrun_kick_flick", {7'd0, flick}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_zero("midrun_reset");
    rst_n = 1'b1;
    fl_state = 3'b000; req_kick = 2'b00; req = 2'b01;
    tick();
    chk("post_reset_gnt", {6'd0, gnt}, 8'd1);
    req = 2'b00;
    pulse_reset();
    chk("reset2_busy", {7'd0, busy}, 8'd0);

    // Round robin with both requesting over three runs.
    req = 2'b11;
    do_run(2'b01, 1'b0, 3'd1);
    do_run(2'b10, 1'b0, 3'd2);
    do_run(2'b01, 1'b0, 3'd3);
    req = 2'b00;

    // Requester 1 with one kickback.
    req = 2'b10; req_kick = 2'b10;
    do_run(2'b10, 1'b1, 3'd4);
    req = 2'b00; req_kick = 2'b00;

    // Counter saturation at all-ones.
    req = 2'b01;
    do_run(2'b01, 1'b0, 3'd5);
    do_run(2'b01, 1'b0, 3'd6);
    do_run(2'b01, 1'b0, 3'd7);
    do_run(2'b01, 1'b0, 3'd7);
    req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
